// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: default widths,
// shift-op encodings and controller state encodings.
package shift_sequencer_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    // 2'b11 is reserved and is executed as a logical right shift
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRA = 2'b01,
        OP_SRL = 2'b10,
        OP_RSV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_sequencer_stage.sv
// Combinational shift stage: shifts by the single power-of-two weight selected
// by the one-hot sel input, filling vacated bits according to the op.
module shift_stage
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] sel,
    input  op_t                op,
    output logic [WIDTH-1:0]   out
);

    logic [SHAMT_W-1:0] amt;

    always_comb begin
        amt = '0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (sel[i]) begin
                amt = SHAMT_W'(1) << i;
            end
        end
    end

    // The working value's MSB always equals the latched operand's sign bit
    // during SRA, so the arithmetic shift replicates the original sign.
    always_comb begin
        out = in;
        case (op)
            OP_SLL:  out = in << amt;
            OP_SRA:  out = $signed(in) >>> amt;
            default: out = in >> amt;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: latches operand/amount/op on start, then
// consumes the shift amount one power-of-two stage per cycle, highest first.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic [1:0]         ctrl_op,
    input  logic [WIDTH-1:0]   data_operand,
    input  logic [SHAMT_W-1:0] ctrl_shamt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);

    state_t             state;
    state_t             next;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   stageOut;
    logic [SHAMT_W-1:0] rem;
    logic [SHAMT_W-1:0] sel;
    op_t                op;
    logic               accept;

    // New requests are only taken when the controller is not mid-shift
    assign accept = ctrl_start && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:  if (ctrl_start) next = S_SHIFT;
            S_SHIFT: if (rem == '0) next = S_DONE;
            S_DONE:  next = ctrl_start ? S_SHIFT : S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_comb begin
        data_resultRDY = (state == S_DONE);
        busy           = (state == S_SHIFT);
    end

    // Priority encoder: one-hot weight of the highest set bit of rem
    always_comb begin
        sel = '0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (rem[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
    end

    shift_stage #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .in  (work),
        .sel (sel),
        .op  (op),
        .out (stageOut)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            work        <= '0;
            rem         <= '0;
            op          <= OP_SLL;
            data_result <= '0;
        end else if (accept) begin
            work <= data_operand;
            rem  <= ctrl_shamt;
            op   <= op_t'(ctrl_op);
        end else if (state == S_SHIFT) begin
            if (rem != '0) begin
                work <= stageOut;
                rem  <= rem & ~sel;
            end else begin
                data_result <= work;
            end
        end
    end

endmodule
